ibex_multicycle_adder: RTL and testbench
========================================

IBEX_MULTICYCLE_ADDER -- requirements
Module: ibex_multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle; legal only when 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port io_in_valid  in  1  operation request.
REQ-006 SHALL have port io_in_ready  out  1  block accepts request this cycle.
REQ-007 SHALL have port io_operand_a_i  in  WIDTH  operand A.
REQ-008 SHALL have port io_operand_b_i  in  WIDTH  operand B.
REQ-009 SHALL have port io_sub_i  in  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port io_out_valid  out  1  result valid.
REQ-011 SHALL have port io_out_ready  in  1  consumer takes result.
REQ-012 SHALL have port io_adder_result_o  out  WIDTH  sum/difference mod 2^WIDTH.
REQ-013 SHALL have port io_adder_result_ext_o  out  WIDTH+2  {carry, result, 1'b1}.
REQ-014 SHALL have port io_carry_o  out  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port io_overflow_o  out  1  signed two's-complement overflow.
REQ-016 SHALL have port io_zero_o  out  1  result == 0.
REQ-017 SHALL have port io_busy_o  out  1  high in BUSY state.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 SHALL drive io_in_ready = (state==IDLE) or (state==DONE and io_out_ready), forced 0 while reset is high.
REQ-020 SHALL, on accept (in_valid & in_ready), capture A, B_eff = sub ? ~B : B, carry = sub, clear chunk counter, enter BUSY.
REQ-021 SHALL, in each BUSY cycle k (0..NCHUNK-1, LSB chunk first), add A chunk k + B_eff chunk k + carry, store the CHUNK-bit sum in working result bits, update carry.
REQ-022 SHALL, after BUSY cycle NCHUNK-1, load output registers (result, ext, carry, overflow, zero) and enter DONE; accept in cycle 0 gives io_out_valid high from cycle NCHUNK+1.
REQ-023 SHALL compute overflow = (A[MSB]==B_eff[MSB]) and (result[MSB]!=A[MSB]); zero = (result==0).
REQ-024 SHALL assert io_out_valid only in DONE; all result outputs SHALL hold stable while DONE and out_ready low.
REQ-025 SHALL, in DONE with out_ready high, return to IDLE, or go directly to BUSY if a new request is accepted the same cycle (no bubble).
REQ-026 SHALL hold output registers at last completed values during IDLE and BUSY; io_in_valid SHALL be ignored in BUSY.
REQ-027 SHALL, with CHUNK==WIDTH, use exactly one BUSY cycle.
REQ-028 SHALL ignore operand/sub changes after accept.

Reset
REQ-029 SHALL, while reset high, set state IDLE, counter, carry, working and output registers to 0; io_out_valid, io_busy_o, io_adder_result_o, io_adder_result_ext_o, flags all 0.
REQ-030 SHALL abandon any in-flight operation on reset (mid-BUSY or DONE); no out_valid for it afterwards.
REQ-031 SHALL assert io_in_ready in the first cycle after reset deasserts.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-032 SHALL cover: add 0xFFFFFFFF+0x1, accept cycle 0 -> out_valid cycle 5, result 0x00000000, carry 1, zero 1, overflow 0, ext 0x200000001.
REQ-033 SHALL cover: sub 5-7 -> result 0xFFFFFFFE, carry 0, overflow 0, zero 0, ext 0x1FFFFFFFD.
REQ-034 SHALL cover: add 0x7FFFFFFF+0x1 -> result 0x80000000, overflow 1, carry 0; sub 0x80000000-1 -> 0x7FFFFFFF, overflow 1, carry 1.
REQ-035 SHALL cover: out_ready low 3 cycles in DONE with in_valid high -> outputs stable, in_ready 0; out_ready rises -> new op accepted same cycle, busy next cycle, its out_valid 5 cycles later.
REQ-036 SHALL cover: reset asserted in BUSY cycle 2 for 1 cycle -> all outputs 0, no out_valid, in_ready 1 next cycle, following 3+4 yields 7.
REQ-037 SHALL cover: CHUNK=32, add 1+2 accepted cycle 0 -> out_valid cycle 2, result 3.

Source files
------------

// File: rtl/ibex_multicycle_adder.sv
// ---------------------------------------------------------------------------
// ibex_multicycle_adder
//   Chunked ripple adder/subtractor. An accepted request is added CHUNK bits
//   per cycle, least-significant chunk first. The final sum and flags are then
//   held in output registers until the consumer takes them.
//
// Parameters
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per cycle. Requires 1 <= CHUNK <= WIDTH and
//          WIDTH % CHUNK == 0.
//
// Ports
//   clock                  sole clock, rising edge
//   reset                  synchronous, active-high
//   io_in_valid / ready    request handshake
//   io_operand_a_i/b_i     operands
//   io_sub_i               0 = A+B, 1 = A-B
//   io_out_valid / ready   result handshake
//   io_adder_result_o      sum/difference mod 2^WIDTH
//   io_adder_result_ext_o  {carry, result, 1'b1}
//   io_carry_o             carry out of MSB (subtract: 1 = no borrow)
//   io_overflow_o          signed two's-complement overflow
//   io_zero_o              result == 0
//   io_busy_o              high while chunks are being added
// ---------------------------------------------------------------------------
module ibex_multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_operand_a_i,
   input  logic [WIDTH-1:0] io_operand_b_i,
   input  logic             io_sub_i,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_adder_result_o,
   output logic [WIDTH+1:0] io_adder_result_ext_o,
   output logic             io_carry_o,
   output logic             io_overflow_o,
   output logic             io_zero_o,
   output logic             io_busy_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_work;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] r_res;
   logic [WIDTH+1:0] r_ext;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_last;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK:0]   w_sum;
   logic [WIDTH-1:0] w_work_next;

   // Reset forces ready low so a request cannot slip in during reset.
   assign w_in_ready = !reset &&
                       ((r_state == IDLE) || ((r_state == DONE) && io_out_ready));
   assign w_accept   = io_in_valid && w_in_ready;
   assign w_last     = (r_cnt == LAST);

   // Select the current chunk, add it, and merge the sum into the working
   // word. The merged word is also what gets registered on the final chunk,
   // so the result and its flags are available without an extra cycle.
   always_comb begin
      w_a_chunk   = '0;
      w_b_chunk   = '0;
      w_work_next = r_work;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (r_cnt == CW'(i)) begin
            w_a_chunk = r_a[i*CHUNK +: CHUNK];
            w_b_chunk = r_b[i*CHUNK +: CHUNK];
         end
      end
      w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (r_cnt == CW'(i)) begin
            w_work_next[i*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = BUSY;
         BUSY: if (w_last)   w_state_next = DONE;
         DONE: begin
            if (io_out_ready) begin
               w_state_next = w_accept ? BUSY : IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_ext   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is A + ~B + 1: invert B and seed the carry.
         r_a     <= io_operand_a_i;
         r_b     <= io_sub_i ? ~io_operand_b_i : io_operand_b_i;
         r_carry <= io_sub_i;
         r_cnt   <= '0;
      end else if (r_state == BUSY) begin
         r_work  <= w_work_next;
         r_carry <= w_sum[CHUNK];
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_res  <= w_work_next;
            r_ext  <= {w_sum[CHUNK], w_work_next, 1'b1};
            r_cout <= w_sum[CHUNK];
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero <= (w_work_next == '0);
         end
      end
   end

   assign io_in_ready           = w_in_ready;
   assign io_out_valid          = (r_state == DONE);
   assign io_busy_o             = (r_state == BUSY);
   assign io_adder_result_o     = r_res;
   assign io_adder_result_ext_o = r_ext;
   assign io_carry_o            = r_cout;
   assign io_overflow_o         = r_ovf;
   assign io_zero_o             = r_zero;

endmodule

// File: tb/tb_ibex_multicycle_adder.sv
// ---------------------------------------------------------------------------
// tb_ibex_multicycle_adder
//   Self-checking bench for ibex_multicycle_adder. It drives a WIDTH=32/CHUNK=8
//   instance and a WIDTH=32/CHUNK=32 instance. Expected values come from an
//   arithmetic model using 64-bit integers.
// ---------------------------------------------------------------------------
module tb_ibex_multicycle_adder;

   logic clock = 1'b0;
   logic reset;

   // CHUNK = 8 instance
   logic        in_valid, in_ready, sub, out_valid, out_ready;
   logic [31:0] op_a, op_b, res;
   logic [33:0] ext;
   logic        carry, ovf, zero, busy;

   // CHUNK = 32 instance
   logic        c_in_valid, c_in_ready, c_sub, c_out_valid, c_out_ready;
   logic [31:0] c_op_a, c_op_b, c_res;
   logic [33:0] c_ext;
   logic        c_carry, c_ovf, c_zero, c_busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [33:0] ext;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   ibex_multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clock                 (clock),
      .reset                 (reset),
      .io_in_valid           (in_valid),
      .io_in_ready           (in_ready),
      .io_operand_a_i        (op_a),
      .io_operand_b_i        (op_b),
      .io_sub_i              (sub),
      .io_out_valid          (out_valid),
      .io_out_ready          (out_ready),
      .io_adder_result_o     (res),
      .io_adder_result_ext_o (ext),
      .io_carry_o            (carry),
      .io_overflow_o         (ovf),
      .io_zero_o             (zero),
      .io_busy_o             (busy)
   );

   ibex_multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clock                 (clock),
      .reset                 (reset),
      .io_in_valid           (c_in_valid),
      .io_in_ready           (c_in_ready),
      .io_operand_a_i        (c_op_a),
      .io_operand_b_i        (c_op_b),
      .io_sub_i              (c_sub),
      .io_out_valid          (c_out_valid),
      .io_out_ready          (c_out_ready),
      .io_adder_result_o     (c_res),
      .io_adder_result_ext_o (c_ext),
      .io_carry_o            (c_carry),
      .io_overflow_o         (c_ovf),
      .io_zero_o             (c_zero),
      .io_busy_o             (c_busy)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: exact signed/unsigned arithmetic, then wrap and derive flags.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t   e;
      longint sa    = longint'($signed(a));
      longint sb    = longint'($signed(b));
      longint ua    = longint'({32'b0, a});
      longint ub    = longint'({32'b0, b});
      longint exact = s ? (sa - sb) : (sa + sb);
      longint usum  = ua + ub;
      e.res = exact[31:0];
      e.c   = s ? (ua >= ub) : (usum > 64'sd4294967295);
      e.v   = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
      e.z   = (e.res == 32'd0);
      e.ext = {e.c, e.res, 1'b1};
      return e;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check_eq({tag, "_res"},   64'(res),   64'(e.res));
      check_eq({tag, "_ext"},   64'(ext),   64'(e.ext));
      check_eq({tag, "_carry"}, 64'(carry), 64'(e.c));
      check_eq({tag, "_ovf"},   64'(ovf),   64'(e.v));
      check_eq({tag, "_zero"},  64'(zero),  64'(e.z));
   endtask

   // Wait for out_valid, counting edges after the accept edge.
   task automatic wait_done(input string tag, input int exp_lat);
      int n = 0;
      while (!out_valid && n < 20) begin
         check_eq({tag, "_busy"}, 64'(busy), 64'(1));
         check_eq({tag, "_in_ready_busy"}, 64'(in_ready), 64'(0));
         tick();
         n++;
      end
      check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int stall);
      exp_t e = model(a, b, s);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check_eq({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
      tick();
      // Scramble inputs and keep valid high: must be ignored while busy.
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
      wait_done(tag, 4);
      in_valid = 1'b0;
      check_outputs(tag, e);
      repeat (stall) begin
         tick();
         check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
         check_outputs({tag, "_hold"}, e);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
      check_outputs({tag, "_idle"}, e);
   endtask

   task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e = model(a, b, s);
      int n = 0;
      c_op_a = a; c_op_b = b; c_sub = s; c_in_valid = 1'b1; c_out_ready = 1'b0;
      tick();
      c_in_valid = 1'b0;
      c_op_a = $urandom; c_op_b = $urandom;
      while (!c_out_valid && n < 20) begin
         check_eq({tag, "_busy"}, 64'(c_busy), 64'(1));
         tick();
         n++;
      end
      check_eq({tag, "_latency"}, 64'(n), 64'(1));
      check_eq({tag, "_res"},   64'(c_res),   64'(e.res));
      check_eq({tag, "_ext"},   64'(c_ext),   64'(e.ext));
      check_eq({tag, "_carry"}, 64'(c_carry), 64'(e.c));
      check_eq({tag, "_ovf"},   64'(c_ovf),   64'(e.v));
      check_eq({tag, "_zero"},  64'(c_zero),  64'(e.z));
      c_out_ready = 1'b1;
      tick();
      c_out_ready = 1'b0;
      check_eq({tag, "_idle_valid"}, 64'(c_out_valid), 64'(0));
   endtask

   initial begin
      exp_t e1;
      exp_t e2;
      reset = 1'b1;
      in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
      c_in_valid = 1'b0; c_op_a = '0; c_op_b = '0; c_sub = 1'b0; c_out_ready = 1'b0;
      tick(); tick();

      check_eq("rst_in_ready",  64'(in_ready),  64'(0));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_busy",      64'(busy),      64'(0));
      check_eq("rst_res",       64'(res),       64'(0));
      check_eq("rst_ext",       64'(ext),       64'(0));
      check_eq("rst_flags",     64'({carry, ovf, zero}), 64'(0));

      reset = 1'b0;
      #1;
      check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));

      // Directed corners
      run_op("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1);
      check_eq("add_wrap_ext_const", 64'(ext), 64'h2_0000_0001);
      run_op("sub_neg",   32'd5,         32'd7, 1'b1, 0);
      check_eq("sub_neg_ext_const", 64'(ext), 64'h1_FFFF_FFFD);
      run_op("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 2);
      run_op("sub_ovf",   32'h8000_0000, 32'h1, 1'b1, 0);
      run_op("sub_zero",  32'h0,         32'h0, 1'b1, 0);
      run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 1);

      // Randomized operations
      for (int i = 0; i < 24; i++) begin
         run_op("rand", $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
      end

      // Back-to-back: stall 3 cycles in DONE with a pending request
      e1 = model(32'h0000_00FF, 32'h0000_0001, 1'b0);
      e2 = model(32'h1000_0000, 32'h2000_0001, 1'b1);
      op_a = 32'h0000_00FF; op_b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1;
      tick();
      op_a = 32'h1000_0000; op_b = 32'h2000_0001; sub = 1'b1;
      wait_done("b2b_first", 4);
      check_outputs("b2b_first", e1);
      repeat (3) begin
         tick();
         check_eq("b2b_stall_in_ready", 64'(in_ready), 64'(0));
         check_eq("b2b_stall_valid",    64'(out_valid), 64'(1));
         check_outputs("b2b_stall", e1);
      end
      out_ready = 1'b1;
      #1;
      check_eq("b2b_release_in_ready", 64'(in_ready), 64'(1));
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_eq("b2b_second_busy",  64'(busy),      64'(1));
      check_eq("b2b_second_valid", 64'(out_valid), 64'(0));
      wait_done("b2b_second", 4);
      check_outputs("b2b_second", e2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset in the second BUSY cycle abandons the operation
      op_a = 32'h0000_1111; op_b = 32'h0000_2222; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check_eq("rst_mid_busy_pre", 64'(busy), 64'(1));
      reset = 1'b1;
      tick();
      check_eq("rst_mid_busy",  64'(busy),      64'(0));
      check_eq("rst_mid_valid", 64'(out_valid), 64'(0));
      check_eq("rst_mid_res",   64'(res),       64'(0));
      check_eq("rst_mid_ext",   64'(ext),       64'(0));
      check_eq("rst_mid_flags", 64'({carry, ovf, zero}), 64'(0));
      reset = 1'b0;
      #1;
      check_eq("rst_mid_in_ready", 64'(in_ready), 64'(1));
      repeat (6) begin
         tick();
         check_eq("rst_mid_no_valid", 64'(out_valid), 64'(0));
      end
      run_op("after_rst", 32'd3, 32'd4, 1'b0, 0);
      check_eq("after_rst_const", 64'(res), 64'd7);

      // Single-chunk instance
      run32("c32_add", 32'd1, 32'd2, 1'b0);
      check_eq("c32_add_const", 64'(c_res), 64'd3);
      run32("c32_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0);
      run32("c32_sub", 32'h8000_0000, 32'h1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run32("c32_rand", $urandom, $urandom, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
